shift_sequencer: RTL and testbench
==================================

// Module: shift_sequencer
//
// PURPOSE
//   Multi-cycle shift unit for the ALU. It accepts an operand, a shift amount and a
//   direction through a start/busy/done handshake, then shifts one bit per clock.
//   It sits between the ALU control FSM (upstream, issues start) and the result/
//   accumulator path (downstream, consumes result on done). It implements the
//   serial 1-bit-per-cycle shift behaviour of the ALU's shift register under
//   counter control.
//
// PARAMETERS
//   WIDTH  16  data path width in bits
//   AMT_W   4  width of the shift-amount field ($clog2(WIDTH))
//
// PORTS
//   clk      in   1      rising-edge clock
//   rst_b    in   1      reset: asynchronous, active-low
//   start    in   1      request a new shift; sampled only in IDLE
//   operand  in   WIDTH  value to shift; captured on accept
//   amount   in   AMT_W  number of bit positions (0..WIDTH-1); captured on accept
//   dir      in   1      1 = right shift, 0 = left shift; captured on accept
//   arith    in   1      right shifts only: 1 = fill with operand MSB, 0 = fill with 0
//   busy     out  1      high in SHIFT and DONE; start is ignored while high
//   done     out  1      one-cycle pulse: result valid
//   result   out  WIDTH  registered shifted value; holds until the next completion
//
// BEHAVIOUR
//   Reset (rst_b=0, async): state=IDLE; busy=0, done=0, result=0; data and count
//     registers = 0. Takes effect immediately, including mid-SHIFT. Any in-flight
//     operation is discarded; no done pulse follows.
//   FSM states: IDLE, SHIFT, DONE. busy/done decode from state (Moore).
//   IDLE: start=1 at edge k -> data<=operand, cnt<=amount, dir/arith latched.
//     If amount==0, next state is DONE. Otherwise next state is SHIFT.
//   SHIFT: at each edge, data shifts 1 bit and cnt decrements.
//     Left: data<={data[W-2:0],1'b0}.
//     Right: data<={fill,data[W-1:1]}, where fill = arith ? data[W-1] : 0.
//     When cnt==1 at the edge: perform the final shift, load result with the shifted
//     value, and go to DONE.
//   DONE: done=1 for exactly one cycle, then next state is IDLE unconditionally.
//     For amount==0, result<=operand on entry to DONE.
//   Latency: with start accepted at edge k, done is high in the cycle after edge
//     k+N (N = amount). Total is N+1 cycles; the next start is accepted at edge k+N+2.
//   start in SHIFT or DONE: ignored; it does not queue. Held start is re-accepted in IDLE.
//   operand/amount/dir/arith changes after accept: no effect on the current operation.
//   Arithmetic: a pure logical/arithmetic shift with no rotate and no carry out.
//     Shifted-out bits are lost.
//   result changes only at the edge entering DONE (or at reset). It is stable otherwise.
//
// TESTING
//   1. operand=16'hB76B, amount=1, dir=0 -> result=16'h6ED6; done 2 cycles after start.
//   2. operand=16'hB76B, amount=4, dir=1, arith=0 -> result=16'h0B76; busy high 5 cycles.
//   3. operand=16'hB76B, amount=4, dir=1, arith=1 -> result=16'hFB76.
//   4. operand=16'hB76B, amount=0 -> result=16'hB76B; done in the cycle after accept.
//   5. Pulse start with a different operand during SHIFT -> ignored; first result is
//      unchanged. Assert rst_b=0 mid-SHIFT -> busy=0 and result=0 immediately, no done.
//   6. Hold start=1 with amount=15, operand=16'h8000, dir=1, arith=1 -> result=16'hFFFF.
//      Back-to-back operations are accepted one cycle after each done pulse.

Source files
------------

// File: rtl/shift_sequencer_if.sv
// shift_sequencer_if: start/busy/done handshake and data bus for the serial shift unit
interface shift_sequencer_if #(
   parameter int WIDTH = 16,
   parameter int AMT_W = 4
);
   logic             start;
   logic [WIDTH-1:0] operand;
   logic [AMT_W-1:0] amount;
   logic             dir;
   logic             arith;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] result;
   modport master (output start, operand, amount, dir, arith, input busy, done, result);
   modport slave  (input start, operand, amount, dir, arith, output busy, done, result);
endinterface

// File: rtl/shift_sequencer.sv
// shift_sequencer: multi-cycle shifter, one bit position per clock under counter control
module shift_sequencer #(
   parameter int WIDTH = 16,
   parameter int AMT_W = 4
) (
   input logic               clk,
   input logic               rst_b,
   shift_sequencer_if.slave  bus
);
   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
   state_t           state, next;
   logic [WIDTH-1:0] data, shifted, result_q;
   logic [AMT_W-1:0] cnt;
   logic             dir_q, arith_q;
   // one-bit shift of the working register; fill bit copies the MSB only for arithmetic right shifts
   always_comb shifted = dir_q ? {arith_q & data[WIDTH-1], data[WIDTH-1:1]} : {data[WIDTH-2:0], 1'b0};
   // state register
   always_ff @(posedge clk or negedge rst_b)
      if (!rst_b) state <= IDLE;
      else state <= next;
   // next state: zero-amount requests skip straight to DONE; DONE always returns to IDLE
   always_comb
      next = (state == IDLE)  ? (bus.start ? ((bus.amount == '0) ? DONE : SHIFT) : IDLE) :
             (state == SHIFT) ? ((cnt == AMT_W'(1)) ? DONE : SHIFT) : IDLE;
   // Moore outputs decoded from state
   always_comb begin
      bus.busy   = (state != IDLE);
      bus.done   = (state == DONE);
      bus.result = result_q;
   end
   // datapath: capture on accept, shift while counting down, publish result on entry to DONE
   always_ff @(posedge clk or negedge rst_b)
      if (!rst_b) begin
         data     <= '0;
         cnt      <= '0;
         dir_q    <= 1'b0;
         arith_q  <= 1'b0;
         result_q <= '0;
      end else if (state == IDLE && bus.start) begin
         data    <= bus.operand;
         cnt     <= bus.amount;
         dir_q   <= bus.dir;
         arith_q <= bus.arith;
         if (bus.amount == '0) result_q <= bus.operand;
      end else if (state == SHIFT) begin
         data <= shifted;
         cnt  <= cnt - AMT_W'(1);
         if (cnt == AMT_W'(1)) result_q <= shifted;
      end
endmodule

// File: tb/tb_shift_sequencer.sv
// tb_shift_sequencer: randomized and directed checks of shift_sequencer against an arithmetic shift model
module tb_shift_sequencer;
   logic clk = 1'b0;
   logic rst_b = 1'b0;
   int   total = 0;
   int   bad = 0;
   shift_sequencer_if #(.WIDTH(16), .AMT_W(4)) bus ();
   shift_sequencer #(.WIDTH(16), .AMT_W(4)) dut (.clk(clk), .rst_b(rst_b), .bus(bus));
   always #5 clk = ~clk;
   // reference: the shift expressed directly with shift operators
   function automatic logic [15:0] model(logic [15:0] op, int amt, logic d, logic a);
      logic signed [15:0] s;
      s = op;
      if (!d) return op << amt;
      if (a) return 16'(s >>> amt);
      return op >> amt;
   endfunction
   task automatic step();
      @(posedge clk);
      #1;
   endtask
   // issue one operation, scramble inputs after accept, and check result, latency and busy length
   task automatic run_op(string name, logic [15:0] op, int amt, logic d, logic a);
      int lat, bcyc;
      logic [15:0] exp_res;
      exp_res = model(op, amt, d, a);
      bus.start = 1'b1; bus.operand = op; bus.amount = 4'(amt); bus.dir = d; bus.arith = a;
      step();
      bus.start = 1'b0; bus.operand = 16'($urandom); bus.amount = 4'($urandom);
      bus.dir = 1'($urandom); bus.arith = 1'($urandom);
      lat = 0; bcyc = 0;
      while (!bus.done && lat < 40) begin
         bcyc += int'(bus.busy);
         step();
         lat++;
      end
      bcyc += int'(bus.busy);
      total++;
      if (!bus.done) begin
         bad++;
         $display("FAIL %s timeout: done not seen within %0d cycles", name, lat);
         return;
      end
      total++;
      if (bus.result !== exp_res) begin
         bad++;
         $display("FAIL %s result: got %h expected %h (op=%h amt=%0d dir=%0b arith=%0b)", name, bus.result, exp_res, op, amt, d, a);
      end
      total++;
      if (lat !== amt || bcyc !== amt + 1) begin
         bad++;
         $display("FAIL %s timing: latency %0d busy %0d expected latency %0d busy %0d", name, lat, bcyc, amt, amt + 1);
      end
      step();
      total++;
      if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.result !== exp_res) begin
         bad++;
         $display("FAIL %s after_done: done=%0b busy=%0b result=%h expected 0 0 %h", name, bus.done, bus.busy, bus.result, exp_res);
      end
   endtask
   task automatic test_reset();
      bus.start = 1'b0; bus.operand = '0; bus.amount = '0; bus.dir = 1'b0; bus.arith = 1'b0;
      rst_b = 1'b0;
      #3;
      total++;
      if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.result !== 16'h0) begin
         bad++;
         $display("FAIL reset: busy=%0b done=%0b result=%h expected 0 0 0000", bus.busy, bus.done, bus.result);
      end
      step();
      rst_b = 1'b1;
      step();
   endtask
   task automatic test_directed();
      run_op("left1", 16'hB76B, 1, 1'b0, 1'b0);
      run_op("right4_log", 16'hB76B, 4, 1'b1, 1'b0);
      run_op("right4_arith", 16'hB76B, 4, 1'b1, 1'b1);
      run_op("amount0", 16'hB76B, 0, 1'b1, 1'b0);
      run_op("left15", 16'hFFFF, 15, 1'b0, 1'b1);
      run_op("right15_log", 16'h8001, 15, 1'b1, 1'b0);
   endtask
   task automatic test_random();
      for (int i = 0; i < 40; i++)
         run_op("random", 16'($urandom), int'($urandom_range(0, 15)), 1'($urandom), 1'($urandom));
   endtask
   // a start pulse during SHIFT must neither queue nor disturb the running operation
   task automatic test_ignore_start();
      int lat;
      logic [15:0] exp_res;
      exp_res = model(16'h1234, 8, 1'b0, 1'b0);
      bus.start = 1'b1; bus.operand = 16'h1234; bus.amount = 4'd8; bus.dir = 1'b0; bus.arith = 1'b0;
      step();
      bus.start = 1'b0;
      step(); step();
      bus.start = 1'b1; bus.operand = 16'hFFFF; bus.amount = 4'd2; bus.dir = 1'b1;
      step();
      bus.start = 1'b0;
      lat = 3;
      while (!bus.done && lat < 40) begin step(); lat++; end
      total++;
      if (!bus.done || lat !== 8 || bus.result !== exp_res) begin
         bad++;
         $display("FAIL ignore_start: done=%0b latency=%0d result=%h expected 1 8 %h", bus.done, lat, bus.result, exp_res);
      end
      for (int i = 0; i < 6; i++) step();
      total++;
      if (bus.busy !== 1'b0 || bus.result !== exp_res) begin
         bad++;
         $display("FAIL ignore_start_queue: busy=%0b result=%h expected 0 %h", bus.busy, bus.result, exp_res);
      end
   endtask
   // asynchronous reset mid-SHIFT clears everything at once and suppresses done
   task automatic test_reset_mid();
      int seen;
      bus.start = 1'b1; bus.operand = 16'h00F0; bus.amount = 4'd10; bus.dir = 1'b0; bus.arith = 1'b0;
      step();
      bus.start = 1'b0;
      step(); step(); step();
      rst_b = 1'b0;
      #1;
      total++;
      if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.result !== 16'h0) begin
         bad++;
         $display("FAIL reset_mid: busy=%0b done=%0b result=%h expected 0 0 0000", bus.busy, bus.done, bus.result);
      end
      step();
      rst_b = 1'b1;
      seen = 0;
      for (int i = 0; i < 15; i++) begin
         step();
         seen += int'(bus.done) + int'(bus.busy);
      end
      total++;
      if (seen !== 0 || bus.result !== 16'h0) begin
         bad++;
         $display("FAIL reset_mid_after: activity=%0d result=%h expected 0 0000", seen, bus.result);
      end
   endtask
   // held start: successive done pulses are N+2 cycles apart
   task automatic test_back_to_back();
      int t, t1, t2;
      bus.start = 1'b1; bus.operand = 16'h8000; bus.amount = 4'd15; bus.dir = 1'b1; bus.arith = 1'b1;
      t = 0; t1 = -1; t2 = -1;
      while (t2 < 0 && t < 100) begin
         step();
         t++;
         if (bus.done) begin
            total++;
            if (bus.result !== 16'hFFFF) begin
               bad++;
               $display("FAIL back_to_back result: got %h expected ffff", bus.result);
            end
            if (t1 < 0) t1 = t;
            else t2 = t;
         end
      end
      bus.start = 1'b0;
      total++;
      if (t1 < 0 || t2 < 0 || t2 - t1 !== 17) begin
         bad++;
         $display("FAIL back_to_back spacing: got %0d expected 17", (t1 < 0 || t2 < 0) ? -1 : t2 - t1);
      end
      for (int i = 0; i < 20; i++) step();
   endtask
   initial begin
      test_reset();
      test_directed();
      test_random();
      test_ignore_start();
      test_reset_mid();
      test_back_to_back();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
